// File: rtl/serial_word_receiver_if.sv
// serial_word_receiver_if: bundles the serial input side and the word
// output handshake of serial_word_receiver.
//   slave  : the receiver (samples sin/sin_valid/dir/clear/pout_ready,
//            drives pout/pout_valid/busy/bit_cnt/overrun)
//   master : whoever feeds the serial line and consumes words
interface serial_word_receiver_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             sin;
  logic             sin_valid;
  logic             dir;
  logic             clear;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  modport slave (
    input  sin, sin_valid, dir, clear, pout_ready,
    output pout, pout_valid, busy, bit_cnt, overrun
  );

  modport master (
    output sin, sin_valid, dir, clear, pout_ready,
    input  pout, pout_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: reassembles WIDTH-bit words from a serial bit stream
// (MSB-first left-shift or LSB-first right-shift) and hands them to the
// datapath through a one-entry valid/ready buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_word_receiver_if.slave
//              sin/sin_valid/dir/clear in, pout/pout_valid/pout_ready
//              handshake, busy/bit_cnt/overrun status out
module serial_word_receiver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_receiver_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_q, ld_d;
  logic             pv_q, pv_d;
  logic             ov_q, ov_d;
  logic             take, eff_dir, last, pop, load;

  // clear wins over sin_valid: the bit on a clear edge is dropped.
  assign take    = bus.sin_valid & ~bus.clear;
  // First bit of a word uses dir directly; later bits use the latched copy.
  assign eff_dir = (state_q == IDLE) ? bus.dir : ld_q;
  assign sr_shift = eff_dir ? {bus.sin, sr_q[WIDTH-1:1]}
                            : {sr_q[WIDTH-2:0], bus.sin};
  assign last    = take && (cnt_q == CNT_W'(WIDTH-1));
  assign pop     = pv_q & bus.pout_ready;
  // Buffer accepts a completed word when empty or being drained this edge.
  assign load    = last && (!pv_q || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      pout_q  <= '0;
      pv_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      pout_q  <= pout_d;
      pv_q    <= pv_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    pout_d  = pout_q;
    pv_d    = pv_q;
    ov_d    = ov_q;

    // Assembly side
    if (bus.clear) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else if (take) begin
      sr_d = sr_shift;
      if (state_q == IDLE) ld_d = bus.dir;
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!load) ov_d = 1'b1;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    // Output buffer side (unaffected by clear)
    if (load) begin
      pout_d = sr_shift;
      pv_d   = 1'b1;
    end else if (pop) begin
      pv_d   = 1'b0;
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pv_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.busy       = (cnt_q != '0);
  assign bus.overrun    = ov_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed vectors with hand-computed expectations
// for serial_word_receiver (WIDTH=8). Inputs change and outputs are sampled
// on the falling edge.
module tb_serial_word_receiver;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  serial_word_receiver_if #(.WIDTH(8), .CNT_W(4)) bus ();

  serial_word_receiver #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; presents one bit across the next rising edge.
  task automatic send_bit(input logic b, input logic d);
    bus.sin       = b;
    bus.dir       = d;
    bus.sin_valid = 1'b1;
    @(negedge clk);
    bus.sin_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // d=0: MSB-first, d=1: LSB-first
  task automatic send_word(input logic [7:0] w, input logic d);
    for (int i = 0; i < 8; i++) send_bit(d ? w[i] : w[7-i], d);
  endtask

  task automatic pop_word();
    bus.pout_ready = 1'b1;
    @(negedge clk);
    bus.pout_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] w;
    rst = 1'b1;
    bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.dir = 1'b0;
    bus.clear = 1'b0; bus.pout_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("rst_pout",    bus.pout, 0);
    chk("rst_valid",   bus.pout_valid, 0);
    chk("rst_cnt",     bus.bit_cnt, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);

    // MSB-first 0,0,0,1,1,1,1,0 -> 0x1E
    seq = 8'b0001_1110;
    for (int k = 1; k <= 8; k++) begin
      send_bit(seq[8-k], 1'b0);
      chk($sformatf("msb_cnt%0d", k), bus.bit_cnt, k % 8);
      chk($sformatf("msb_busy%0d", k), bus.busy, (k < 8) ? 1 : 0);
      if (k < 8) chk($sformatf("msb_nv%0d", k), bus.pout_valid, 0);
    end
    chk("msb_pout",  bus.pout, 8'h1E);
    chk("msb_valid", bus.pout_valid, 1);
    pop_word();
    chk("pop_valid", bus.pout_valid, 0);
    chk("pop_hold",  bus.pout, 8'h1E);

    // LSB-first, same line sequence -> 0x78
    for (int k = 1; k <= 8; k++) send_bit(seq[8-k], 1'b1);
    chk("lsb_pout",  bus.pout, 8'h78);
    chk("lsb_valid", bus.pout_valid, 1);
    pop_word();

    // dir flips to 0 after bit 3; latched dir keeps LSB-first
    for (int k = 1; k <= 8; k++) send_bit(seq[8-k], (k <= 3) ? 1'b1 : 1'b0);
    chk("dirlatch_pout", bus.pout, 8'h78);
    pop_word();

    // 0xA5 MSB-first with a 3-cycle gap after bit 4
    w = 8'hA5;
    for (int i = 0; i < 4; i++) send_bit(w[7-i], 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle(1);
      chk($sformatf("gap_cnt%0d", g), bus.bit_cnt, 4);
    end
    for (int i = 4; i < 8; i++) send_bit(w[7-i], 1'b0);
    chk("gap_pout", bus.pout, 8'hA5);
    chk("gap_ovr",  bus.overrun, 0);
    pop_word();

    // back-to-back, no drain: second word dropped
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    chk("ovr_pout",  bus.pout, 8'h11);
    chk("ovr_valid", bus.pout_valid, 1);
    chk("ovr_flag",  bus.overrun, 1);
    pop_word();
    chk("ovr_pop_valid", bus.pout_valid, 0);
    chk("ovr_sticky",    bus.overrun, 1);

    // clear alone drops overrun
    bus.clear = 1'b1; idle(1); bus.clear = 1'b0;
    chk("clr_ovr", bus.overrun, 0);

    // simultaneous pop + push
    send_word(8'h11, 1'b0);
    w = 8'h33;
    for (int i = 0; i < 7; i++) send_bit(w[7-i], 1'b0);
    chk("pp_pre_pout", bus.pout, 8'h11);
    bus.pout_ready = 1'b1;
    send_bit(w[0], 1'b0);
    bus.pout_ready = 1'b0;
    chk("pp_pout",  bus.pout, 8'h33);
    chk("pp_valid", bus.pout_valid, 1);
    chk("pp_ovr",   bus.overrun, 0);

    // overrun again, then clear mid-word (with sin_valid on the clear edge)
    send_word(8'hFF, 1'b0);
    chk("ab_ovr_set", bus.overrun, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("ab_cnt5", bus.bit_cnt, 5);
    bus.clear = 1'b1;
    send_bit(1'b1, 1'b0);
    bus.clear = 1'b0;
    chk("ab_cnt0",  bus.bit_cnt, 0);
    chk("ab_busy",  bus.busy, 0);
    chk("ab_ovr",   bus.overrun, 0);
    chk("ab_pout",  bus.pout, 8'h33);
    chk("ab_valid", bus.pout_valid, 1);
    pop_word();
    send_word(8'hC3, 1'b0);
    chk("ab_c3",     bus.pout, 8'hC3);
    chk("ab_c3_ovr", bus.overrun, 0);

    // reset mid-word with buffer full
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("mrst_pout",  bus.pout, 0);
    chk("mrst_valid", bus.pout_valid, 0);
    chk("mrst_cnt",   bus.bit_cnt, 0);
    chk("mrst_busy",  bus.busy, 0);
    chk("mrst_ovr",   bus.overrun, 0);

    // clean word after reset
    send_word(8'h5A, 1'b1);
    chk("post_pout",  bus.pout, 8'h5A);
    chk("post_valid", bus.pout_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
